// File: rtl/nbit1x4_demux_reg.sv
`default_nettype none
// ============================================================================
//  Module   : nbit1x4_demux_reg
//  Purpose  : Registered n-bit 1-to-4 demultiplexer with valid/ready
//             handshaking. One input word is steered to one of four output
//             channels by S. Each channel owns a one-entry holding register,
//             so a stalled consumer only blocks traffic addressed to itself.
//  Config   : `define DEMUX_DLV_CNT_EN adds one delivery counter per channel
//             (CNT_W bits, wrapping). Without it, dlv_cnt is tied to zero and
//             no counter flops exist.
//  Revision : 1.0  initial release
// ============================================================================
module nbit1x4_demux_reg #(
    parameter int n     = 8,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [n-1:0]       D,
    input  logic [1:0]         S,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [n-1:0]       Y0,
    output logic [n-1:0]       Y1,
    output logic [n-1:0]       Y2,
    output logic [n-1:0]       Y3,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [4*CNT_W-1:0] dlv_cnt
);

    // Per-channel holding registers; unpacked so each channel's flops have
    // exactly one driving process.
    logic [n-1:0] r_y     [4];
    logic         r_valid [4];

    logic         w_accept;
    logic [3:0]   w_load;
    logic [3:0]   w_deliver;

    // A channel can take a word when empty, or when its current word leaves
    // on the same edge (full-throughput pass-through).
    assign in_ready = ~r_valid[S] | out_ready[S];
    assign w_accept = in_valid & in_ready;

    // One-hot load strobe for the selected channel and per-channel deliver.
    always_comb begin
        w_load = 4'b0000;
        if (w_accept) begin
            w_load[S] = 1'b1;
        end
        for (int k = 0; k < 4; k++) begin
            w_deliver[k] = r_valid[k] & out_ready[k];
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_ch
        // Channel k: load wins over deliver so a simultaneous pair keeps the
        // channel full; a lone deliver empties it and leaves the data alone.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_y[k]     <= '0;
                r_valid[k] <= 1'b0;
            end else if (w_load[k]) begin
                r_y[k]     <= D;
                r_valid[k] <= 1'b1;
            end else if (w_deliver[k]) begin
                r_valid[k] <= 1'b0;
            end
        end
    end

    assign Y0        = r_y[0];
    assign Y1        = r_y[1];
    assign Y2        = r_y[2];
    assign Y3        = r_y[3];
    assign out_valid = {r_valid[3], r_valid[2], r_valid[1], r_valid[0]};

`ifdef DEMUX_DLV_CNT_EN
    logic [CNT_W-1:0] r_cnt [4];

    for (genvar k = 0; k < 4; k++) begin : g_cnt
        // Count words handed to consumer k; natural wrap at 2^CNT_W.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt[k] <= '0;
            end else if (w_deliver[k]) begin
                r_cnt[k] <= r_cnt[k] + 1'b1;
            end
        end
        assign dlv_cnt[k*CNT_W +: CNT_W] = r_cnt[k];
    end
`else
    assign dlv_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nbit1x4_demux_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nbit1x4_demux_reg
//  Purpose  : Directed self-checking bench for nbit1x4_demux_reg (n=8,
//             CNT_W=2). A reference model of four holding slots tracks the
//             expected outputs; a negedge process compares every cycle, and
//             literal expectations pin the model at key points.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nbit1x4_demux_reg;

    localparam int c_N     = 8;
    localparam int c_CNT_W = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [c_N-1:0]     D;
    logic [1:0]         S;
    logic               in_valid;
    logic               in_ready;
    logic [c_N-1:0]     Y0, Y1, Y2, Y3;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [4*c_CNT_W-1:0] dlv_cnt;

    int n_vec = 0;
    int n_err = 0;

    nbit1x4_demux_reg #(.n(c_N), .CNT_W(c_CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .D         (D),
        .S         (S),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Y0        (Y0),
        .Y1        (Y1),
        .Y2        (Y2),
        .Y3        (Y3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dlv_cnt   (dlv_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: four slots, each an optional word plus a delivery tally.
    logic [c_N-1:0] m_word [4];
    bit             m_full [4];
    int             m_dlv  [4];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                m_word[k] = '0;
                m_full[k] = 0;
                m_dlv[k]  = 0;
            end
        end else begin
            bit can_take;
            can_take = !m_full[S] || out_ready[S];
            for (int k = 0; k < 4; k++) begin
                if (m_full[k] && out_ready[k]) begin
                    m_full[k] = 0;
`ifdef DEMUX_DLV_CNT_EN
                    m_dlv[k] = (m_dlv[k] + 1) % (1 << c_CNT_W);
`endif
                end
            end
            if (in_valid && can_take) begin
                m_word[S] = D;
                m_full[S] = 1;
            end
        end
    end

    function automatic logic [3:0] exp_valid();
        return {m_full[3], m_full[2], m_full[1], m_full[0]};
    endfunction

    function automatic logic [4*c_CNT_W-1:0] exp_cnt();
        logic [4*c_CNT_W-1:0] v;
        for (int k = 0; k < 4; k++) v[k*c_CNT_W +: c_CNT_W] = m_dlv[k][c_CNT_W-1:0];
        return v;
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("cyc_Y0", Y0, m_word[0]);
        check("cyc_Y1", Y1, m_word[1]);
        check("cyc_Y2", Y2, m_word[2]);
        check("cyc_Y3", Y3, m_word[3]);
        check("cyc_out_valid", out_valid, exp_valid());
        check("cyc_in_ready", in_ready, !m_full[S] || out_ready[S]);
        check("cyc_dlv_cnt", dlv_cnt, exp_cnt());
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] s);
        D = d; S = s; in_valid = 1'b1;
    endtask

    initial begin
        logic [7:0] words [8];
        int accepts;
        words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

        rst = 1'b1; D = '0; S = 2'b00; in_valid = 1'b0; out_ready = 4'b0000;
        #1;
        check("reset_out_valid", out_valid, 4'b0000);
        check("reset_Y0", Y0, 8'h00);
        check("reset_dlv_cnt", dlv_cnt, '0);
        tick(); tick();
        rst = 1'b0;

        // Steering: one word per channel, everything drains the next cycle.
        out_ready = 4'b1111;
        send(8'h03, 2'b00); #1 check("steer_in_ready0", in_ready, 1'b1); tick();
        check("steer_Y0", Y0, 8'h03); check("steer_ov0", out_valid, 4'b0001);
        send(8'h0C, 2'b01); tick();
        check("steer_Y1", Y1, 8'h0C); check("steer_ov1", out_valid, 4'b0010);
        send(8'h30, 2'b10); tick();
        check("steer_Y2", Y2, 8'h30); check("steer_ov2", out_valid, 4'b0100);
        send(8'hC0, 2'b11); #1 check("steer_in_ready3", in_ready, 1'b1); tick();
        check("steer_Y3", Y3, 8'hC0); check("steer_ov3", out_valid, 4'b1000);
        in_valid = 1'b0; tick();

        // Backpressure on channel 2.
        out_ready = 4'b1011;
        send(8'h30, 2'b10); tick();
        check("bp_Y2_first", Y2, 8'h30);
        send(8'h55, 2'b10); #1 check("bp_in_ready_low", in_ready, 1'b0);
        tick();
        check("bp_Y2_held", Y2, 8'h30); check("bp_ov2_held", out_valid[2], 1'b1);
        out_ready = 4'b1111; #1 check("bp_in_ready_up", in_ready, 1'b1);
        tick();
        check("bp_Y2_new", Y2, 8'h55); check("bp_ov2_stays", out_valid[2], 1'b1);
        in_valid = 1'b0; tick();
        check("bp_ov2_drained", out_valid[2], 1'b0);

        // Isolation: Y1 stalled full, channel 3 still accepts.
        out_ready = 4'b1101;
        send(8'hAA, 2'b01); tick();
        send(8'hC0, 2'b11); #1 check("iso_in_ready", in_ready, 1'b1);
        tick();
        check("iso_Y3", Y3, 8'hC0); check("iso_Y1", Y1, 8'hAA);
        check("iso_ov", out_valid, 4'b1010);
        in_valid = 1'b0; out_ready = 4'b1111; tick();

        // Pass-through: 8 back-to-back words to Y0.
        accepts = 0;
        for (int i = 0; i < 8; i++) begin
            send(words[i], 2'b00);
            #1 if (in_ready) accepts++;
            tick();
            check("pass_Y0", Y0, words[i]);
        end
        check("pass_accepts", accepts, 8);
        in_valid = 1'b0; tick();

        // Mid-run reset with all four channels full.
        out_ready = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            send(8'h10 + 8'(k), 2'(k)); tick();
        end
        in_valid = 1'b0;
        check("full_ov", out_valid, 4'b1111);
        #2 rst = 1'b1; #1;
        check("mid_rst_ov", out_valid, 4'b0000);
        check("mid_rst_Y", {Y3, Y2, Y1, Y0}, 32'h0);
        check("mid_rst_cnt", dlv_cnt, '0);
        tick(); rst = 1'b0;

        // Delivery counter on channel 0 (CNT_W = 2).
        out_ready = 4'b0001;
        send(8'h01, 2'b00); tick();
        for (int i = 0; i < 5; i++) begin
            D = 8'h02 + 8'(i); tick();
`ifdef DEMUX_DLV_CNT_EN
            check("cnt_ch0", dlv_cnt[1:0], 2'((i + 1) % 4));
`else
            check("cnt_off", dlv_cnt, '0);
`endif
            check("cnt_others", dlv_cnt[7:2], 6'h0);
        end
        in_valid = 1'b0; tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
`default_nettype wire
